mux_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4:1 mux path (inputs a..d, selects c1/c0) among four requesters.
- Grants exclusive ownership per transaction and drives the mux select lines.
- Enforces a one-cycle turnaround between owners and an optional hold timeout so that no requester can starve the others.
- Sits in the controller, directly in front of mux_4_1. Output sel[1] drives c1 and sel[0] drives c0.

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

  typedef logic [SEL_W-1:0] req_idx_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set request after ptr, with wrap-around.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic               any,
  output req_idx_t           win
);

  // Scan from lowest priority (ptr itself) to highest (ptr+1) so the last hit wins.
  always_comb begin
    any = |req;
    win = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[req_idx_t'(ptr + SEL_W'(i))]) begin
        win = req_idx_t'(ptr + SEL_W'(i));
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux path, with turnaround and hold timeout.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               timeout,
  output logic [SEL_W-1:0]   owner
);

  localparam int unsigned CNT_RAW = $clog2(MAX_HOLD + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  req_idx_t            owner_q, owner_d;
  req_idx_t            ptr_q, ptr_d;
  logic                valid_q, valid_d;
  logic                to_q, to_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pick_any;
  req_idx_t            pick_win;
  logic                rel_done;
  logic                rel_drop;
  logic                rel_hold;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  // Release causes while owning; done/drop take precedence over the hold limit.
  assign rel_done = done[owner_q];
  assign rel_drop = ~req[owner_q];
  assign rel_hold = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= req_idx_t'(NUM_REQ - 1);
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = idx_onehot(pick_win);
          owner_d = pick_win;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_d = TURN;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = owner_q;
          to_d    = ~(rel_done || rel_drop);
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = owner_q;
  assign owner     = owner_q;
  assign sel_valid = valid_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: vector table on a MAX_HOLD=16 instance,
// hand sequences for hold timeout (MAX_HOLD=4) and asynchronous reset.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, done_a, req_b, done_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b, own_a, own_b;
  logic       sv_a, sv_b, to_a, to_b;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
    .gnt(gnt_a), .sel(sel_a), .sel_valid(sv_a), .timeout(to_a), .owner(own_a)
  );

  mux_rr_arbiter #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .sel(sel_b), .sel_valid(sv_b), .timeout(to_b), .owner(own_b)
  );

  // Packed view {gnt, sel, valid, timeout, owner}.
  function automatic logic [9:0] pack(input logic [3:0] g, input logic [1:0] s,
                                      input logic v, input logic t, input logic [1:0] o);
    return {g, s, v, t, o};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got gnt/sel/valid/to/own=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                     input logic [1:0] s, input logic v, input logic t);
    vec_t e;
    e.req = r; e.done = d; e.gnt = g; e.sel = s; e.valid = v; e.to = t;
    tbl.push_back(e);
  endtask

  task automatic step_a(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    req_a  = r;
    done_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    req_b  = r;
    done_b = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w;
    logic [3:0] oh;
    logic [9:0] exp_b;

    // Full rotation with req=1111, two grant cycles then done.
    for (int k = 0; k < 5; k++) begin
      w  = 2'(k % 4);
      oh = 4'b0001 << w;
      add(4'b1111, 4'b0000, oh,      w, 1'b1, 1'b0);
      add(4'b1111, 4'b0000, oh,      w, 1'b1, 1'b0);
      add(4'b1111, oh,      4'b0000, w, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b0000, w, 1'b0, 1'b0);
    end
    // Owner 1 with a non-owner done that must be ignored; next grant goes to 0.
    add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0011, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Single requester 2: five grant cycles, done, then req drop releases.
    add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0);

    rst_n  = 1'b0;
    req_a  = '0; done_a = '0;
    req_b  = '0; done_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_a", pack(gnt_a, sel_a, sv_a, to_a, own_a), 10'b0);
    check("reset_b", pack(gnt_b, sel_b, sv_b, to_b, own_b), 10'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step_a(tbl[i].req, tbl[i].done);
      check($sformatf("row%0d", i), pack(gnt_a, sel_a, sv_a, to_a, own_a),
            pack(tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].to, tbl[i].sel));
    end

    // MAX_HOLD=4: timeout release, regrant, then done coincident with the hold limit.
    for (int k = 1; k <= 12; k++) begin
      step_b(4'b0001, (k == 11) ? 4'b0001 : 4'b0000);
      if ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) exp_b = pack(4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
      else if (k == 5)                                 exp_b = pack(4'b0000, 2'd0, 1'b0, 1'b1, 2'd0);
      else                                             exp_b = pack(4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
      check($sformatf("hold_edge%0d", k), pack(gnt_b, sel_b, sv_b, to_b, own_b), exp_b);
    end
    step_b(4'b0000, 4'b0000);
    check("hold_idle", pack(gnt_b, sel_b, sv_b, to_b, own_b), 10'b0);

    // Asynchronous reset in the middle of owner 3's grant.
    step_a(4'b1000, 4'b0000);
    check("own3_grant", pack(gnt_a, sel_a, sv_a, to_a, own_a),
          pack(4'b1000, 2'd3, 1'b1, 1'b0, 2'd3));
    step_a(4'b1000, 4'b0000);
    check("own3_hold", pack(gnt_a, sel_a, sv_a, to_a, own_a),
          pack(4'b1000, 2'd3, 1'b1, 1'b0, 2'd3));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", pack(gnt_a, sel_a, sv_a, to_a, own_a), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 4'b1001;
    @(posedge clk);
    #1;
    check("post_reset_grant", pack(gnt_a, sel_a, sv_a, to_a, own_a),
          pack(4'b0001, 2'd0, 1'b1, 1'b0, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
